// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// default timing parameters and the stage-enable bundle layout.
package pipe_ctrl_pkg;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_MUL_WAIT = 2'd2;
   localparam logic [1:0] ST_FLUSH    = 2'd3;

   localparam int DEF_FLUSH_CYCLES = 1;
   localparam int DEF_MAX_WAIT     = 64;

   // Bit order runs front to back along the pipe: pc is the MSB.
   typedef struct packed {
      logic pc;
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } stage_en_t;

   localparam stage_en_t EN_NONE   = 5'b00000;
   localparam stage_en_t EN_ALL    = 5'b11111;
   localparam stage_en_t EN_FREEZE = 5'b00111;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: drives stage enables, IF/ID
// flush and ID/EX bubble, tracks memory/multiplier waits with a watchdog.
module pipeline_hazard_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
   parameter int MAX_WAIT     = DEF_MAX_WAIT,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             freeze,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   input  logic             mul_start,
   input  logic             mul_done,
   input  logic             err_clr,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       state,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   logic [1:0]     state_q, state_d;
   logic [1:0]     flush_remain_q, flush_remain_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           timeout_err_q, timeout_err_d;

   stage_en_t en;
   logic      flush_c, bubble_c, branch_acc, set_err, release_c, done;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      en             = EN_NONE;
      flush_c        = 1'b0;
      bubble_c       = 1'b0;
      branch_acc     = 1'b0;
      set_err        = 1'b0;
      release_c      = 1'b0;
      done           = 1'b0;
      state_d        = state_q;
      flush_remain_d = flush_remain_q;
      wait_cnt_d     = wait_cnt_q;

      case (state_q)
         ST_RUN: begin
            if (dmem_req && !dmem_ack) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WCW'(1);
            end else if (mul_start && !mul_done) begin
               state_d    = ST_MUL_WAIT;
               wait_cnt_d = WCW'(1);
            end else begin
               release_c = 1'b1;
            end
         end
         ST_MEM_WAIT, ST_MUL_WAIT: begin
            done = (state_q == ST_MEM_WAIT) ? dmem_ack : mul_done;
            if (done) begin
               release_c = 1'b1;
            end else if (wait_cnt_q >= WCW'(MAX_WAIT)) begin
               release_c = 1'b1;
               set_err   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end
         default: begin
            // Wrong-path cycle: branch and freeze are ignored, only a memory stall interrupts.
            if (dmem_req && !dmem_ack) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WCW'(1);
            end else begin
               en             = EN_ALL;
               flush_c        = 1'b1;
               bubble_c       = 1'b1;
               flush_remain_d = flush_remain_q - 2'd1;
               state_d        = (flush_remain_d == 2'd0) ? ST_RUN : ST_FLUSH;
            end
         end
      endcase

      // Release cycle of RUN or a wait: branch, then freeze, then free-running.
      if (release_c) begin
         wait_cnt_d = '0;
         if (branch_taken) begin
            en             = EN_ALL;
            flush_c        = 1'b1;
            bubble_c       = 1'b1;
            branch_acc     = 1'b1;
            flush_remain_d = 2'(FLUSH_CYCLES);
         end else if (freeze) begin
            en       = EN_FREEZE;
            bubble_c = 1'b1;
         end else begin
            en = EN_ALL;
         end
         state_d = (flush_remain_d != 2'd0) ? ST_FLUSH : ST_RUN;
      end

      if (set_err) begin
         timeout_err_d = 1'b1;
      end else if (err_clr) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_RUN;
         flush_remain_q <= 2'd0;
         wait_cnt_q     <= '0;
         timeout_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         flush_remain_q <= flush_remain_d;
         wait_cnt_q     <= wait_cnt_d;
         timeout_err_q  <= timeout_err_d;
      end
   end

   assign pc_en       = rst_n & en.pc;
   assign ifid_en     = rst_n & en.ifid;
   assign idex_en     = rst_n & en.idex;
   assign exmem_en    = rst_n & en.exmem;
   assign memwb_en    = rst_n & en.memwb;
   assign ifid_flush  = rst_n & flush_c;
   assign idex_bubble = rst_n & bubble_c;
   assign state       = state_q;
   assign timeout_err = timeout_err_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (!pc_en),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (branch_acc),
      .count (flush_events)
   );

endmodule
